// File: rtl/secded_stream_decoder.sv
// Two-stage Extended Hamming(13,8) SECDED decoder with valid/ready stall and
// saturating corrected/uncorrectable word counters.
module secded_stream_decoder #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [39:0]           codeword_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error_corrected,
  output logic                  error_detected,
  output logic [3:0]            out_syndrome,
  input  logic                  clr_counts,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count
);

  function automatic logic [3:0] calc_syndrome(input logic [12:0] cw);
    logic [3:0] s;
    logic [4:0] pos;
    s = '0;
    for (int j = 0; j < 12; j++) begin
      pos = 5'(j + 1);
      for (int i = 0; i < 4; i++) begin
        if (pos[i]) s[i] = s[i] ^ cw[j];
      end
    end
    return s;
  endfunction

  // Flip the addressed bit only for a single error inside positions 1..12.
  function automatic logic [12:0] correct_word(input logic [12:0] cw,
                                               input logic [3:0]  s,
                                               input logic        p);
    logic [12:0] fixed;
    fixed = cw;
    if (p && (s != 4'd0) && (s <= 4'd12)) fixed[s - 4'd1] = ~cw[s - 4'd1];
    return fixed;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract_data(input logic [12:0] cw);
    return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic                  advance;
  logic                  xfer_out;
  logic                  unused_hi;
  logic                  vld_p1;
  logic [12:0]           cw_p1;
  logic [3:0]            syn_p1;
  logic                  par_p1;
  logic                  corr_c;
  logic                  det_c;
  logic [12:0]           cw_fix_c;
  logic                  vld_p2;
  logic [DATA_WIDTH-1:0] data_p2;
  logic                  corr_p2;
  logic                  det_p2;
  logic [3:0]            syn_p2;

  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign xfer_out  = vld_p2 && out_ready;
  assign unused_hi = ^codeword_in[39:13];

  // Stage 1: capture codeword, syndrome and overall parity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      cw_p1  <= codeword_in[12:0];
      syn_p1 <= calc_syndrome(codeword_in[12:0]);
      par_p1 <= ^codeword_in[12:0];
    end
  end

  always_comb begin
    corr_c   = par_p1 && (syn_p1 <= 4'd12);
    det_c    = (syn_p1 != 4'd0) && (!par_p1 || (syn_p1 > 4'd12));
    cw_fix_c = correct_word(cw_p1, syn_p1, par_p1);
  end

  // Stage 2: corrected data and classification, driving the output port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      corr_p2 <= 1'b0;
      det_p2  <= 1'b0;
      syn_p2  <= '0;
    end else if (advance) begin
      vld_p2  <= vld_p1;
      data_p2 <= extract_data(cw_fix_c);
      corr_p2 <= corr_c;
      det_p2  <= det_c;
      syn_p2  <= syn_p1;
    end
  end

  assign out_valid       = vld_p2;
  assign data_out        = data_p2;
  assign error_corrected = corr_p2;
  assign error_detected  = det_p2;
  assign out_syndrome    = syn_p2;

  // Counters advance on output transfer; a clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (xfer_out) begin
      if (corr_p2) corr_count   <= sat_inc(corr_count);
      if (det_p2)  uncorr_count <= sat_inc(uncorr_count);
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed vector bench for secded_stream_decoder: table of codewords with
// hand-decoded results, plus stall, counter and reset sequences.
module tb_secded_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] codeword_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        error_corrected;
  logic        error_detected;
  logic [3:0]  out_syndrome;
  logic        clr_counts;
  logic [15:0] corr_count;
  logic [15:0] uncorr_count;

  int n_vec = 0;
  int n_bad = 0;

  secded_stream_decoder #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .codeword_in(codeword_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .error_corrected(error_corrected), .error_detected(error_detected),
    .out_syndrome(out_syndrome), .clr_counts(clr_counts),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [39:0] cw;
    logic [7:0]  data;
    logic        corr;
    logic        det;
    logic [3:0]  syn;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_one(input logic [39:0] cw);
    @(negedge clk);
    codeword_in = cw;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  int          exp_corr;
  int          exp_unc;
  logic [7:0]  bp_words_data[4];
  logic [39:0] bp_words[4];
  int          sent;
  int          rcvd;
  logic [7:0]  held_data;
  logic [3:0]  held_syn;

  initial begin
    tbl[0]  = '{40'h0000000A27, 8'hA5, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{40'h0000000A07, 8'hA5, 1'b1, 1'b0, 4'd6};
    tbl[2]  = '{40'h0000001A27, 8'hA5, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{40'h0000000823, 8'h84, 1'b0, 1'b1, 4'd9};
    tbl[4]  = '{40'h0000000AAE, 8'hA5, 1'b0, 1'b1, 4'd13};
    tbl[5]  = '{40'h0000000A26, 8'hA5, 1'b1, 1'b0, 4'd1};
    tbl[6]  = '{40'h0000000227, 8'hA5, 1'b1, 1'b0, 4'd12};
    tbl[7]  = '{40'h0000000AA7, 8'hA5, 1'b1, 1'b0, 4'd8};
    tbl[8]  = '{40'h0000000000, 8'h00, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{40'h0000000003, 8'h00, 1'b0, 1'b1, 4'd3};
    tbl[10] = '{40'h000000008A, 8'h00, 1'b0, 1'b1, 4'd14};
    tbl[11] = '{40'hFFFFFFEA27, 8'hA5, 1'b0, 1'b0, 4'd0};

    rst_n = 1'b0; in_valid = 1'b0; codeword_in = '0; out_ready = 1'b1; clr_counts = 1'b0;
    #23;
    check("rst out_valid", 32'(out_valid), 0);
    check("rst in_ready", 32'(in_ready), 1);
    check("rst data_out", 32'(data_out), 0);
    check("rst flags", {30'd0, error_corrected, error_detected}, 0);
    check("rst syndrome", 32'(out_syndrome), 0);
    check("rst counts", {corr_count, uncorr_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven single words, no stall
    exp_corr = 0; exp_unc = 0;
    for (int k = 0; k < 12; k++) begin
      send_one(tbl[k].cw);
      check($sformatf("v%0d latency", k), 32'(out_valid), 0);
      @(negedge clk);
      check($sformatf("v%0d out_valid", k), 32'(out_valid), 1);
      check($sformatf("v%0d data", k), 32'(data_out), 32'(tbl[k].data));
      check($sformatf("v%0d corr", k), 32'(error_corrected), 32'(tbl[k].corr));
      check($sformatf("v%0d det", k), 32'(error_detected), 32'(tbl[k].det));
      check($sformatf("v%0d syn", k), 32'(out_syndrome), 32'(tbl[k].syn));
      check($sformatf("v%0d corr_count", k), 32'(corr_count), exp_corr);
      check($sformatf("v%0d uncorr_count", k), 32'(uncorr_count), exp_unc);
      if (tbl[k].corr) exp_corr++;
      if (tbl[k].det)  exp_unc++;
    end
    @(negedge clk);
    check("table corr_count", 32'(corr_count), exp_corr);
    check("table uncorr_count", 32'(uncorr_count), exp_unc);

    // backpressure: 4 words, out_ready low for 3 cycles mid-stream
    bp_words[0] = 40'h0A27; bp_words_data[0] = 8'hA5;
    bp_words[1] = 40'h0000; bp_words_data[1] = 8'h00;
    bp_words[2] = 40'h0823; bp_words_data[2] = 8'h84;
    bp_words[3] = 40'h0A07; bp_words_data[3] = 8'hA5;
    sent = 0; rcvd = 0; held_data = '0; held_syn = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      out_ready   = !(c >= 3 && c <= 5);
      in_valid    = (sent < 4);
      codeword_in = (sent < 4) ? bp_words[sent] : 40'h0;
      #1;
      if (c == 3) begin
        held_data = data_out;
        held_syn  = out_syndrome;
        check("bp stall out_valid", 32'(out_valid), 1);
      end
      if (c >= 3 && c <= 5) begin
        check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 0);
        check($sformatf("bp hold data c%0d", c), 32'(data_out), 32'(held_data));
        check($sformatf("bp hold syn c%0d", c), 32'(out_syndrome), 32'(held_syn));
      end
      if (out_valid && out_ready) begin
        if (rcvd < 4)
          check($sformatf("bp word%0d data", rcvd), 32'(data_out), 32'(bp_words_data[rcvd]));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp words received", rcvd, 4);
    exp_corr++; exp_unc++;
    @(negedge clk);
    check("bp corr_count", 32'(corr_count), exp_corr);
    check("bp uncorr_count", 32'(uncorr_count), exp_unc);

    // clear, then saturate corr_count
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr counts", {corr_count, uncorr_count}, 0);
    codeword_in = 40'h0A07;
    in_valid    = 1'b1;
    repeat (65535) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("corr_count at max", 32'(corr_count), 32'h0000FFFF);
    send_one(40'h0A07);
    repeat (3) @(negedge clk);
    check("corr_count saturated", 32'(corr_count), 32'h0000FFFF);
    check("uncorr_count unchanged", 32'(uncorr_count), 0);

    // clr_counts coinciding with a corrected-word transfer
    send_one(40'h0A07);
    @(negedge clk);
    check("clr+xfer out_valid", 32'(out_valid), 1);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    check("clr+xfer corr_count", 32'(corr_count), 0);

    // asynchronous reset mid-stream
    @(negedge clk);
    codeword_in = 40'h0823; in_valid = 1'b1;
    @(negedge clk);
    codeword_in = 40'h0A07;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset out_valid", 32'(out_valid), 1);
    check("pre-reset uncorr_count", 32'(uncorr_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 0);
    check("mid reset counts", {corr_count, uncorr_count}, 0);
    check("mid reset data", 32'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset no stale word", 32'(out_valid), 0);
    send_one(40'h0A27);
    @(negedge clk);
    check("post reset data", 32'(data_out), 32'h000000A5);
    check("post reset valid", 32'(out_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
